msg_frame_ctrl: RTL and testbench

//  Sequences parsing of one AXI-Stream packet into messages. Consumes the packet header (message count), then each

---
 rtl/msg_frame_ctrl.sv | 144 ++++++++++++++
 tb/tb_msg_frame_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/msg_frame_ctrl.sv
// msg_frame_ctrl: splits one AXI-Stream packet into length-prefixed messages and forwards
// payload beats with per-message byte masks through a one-deep output register slice.
module msg_frame_ctrl #(
    parameter int TDATA_WIDTH = 64,
    parameter int TKEEP_WIDTH = 8,
    parameter int MAX_LEN     = 1500
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [TDATA_WIDTH-1:0] s_tdata,
    input  logic [TKEEP_WIDTH-1:0] s_tkeep,
    input  logic                   s_tlast,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [TDATA_WIDTH-1:0] m_data,
    output logic [TKEEP_WIDTH-1:0] m_keep,
    output logic                   m_sop,
    output logic                   m_eop,
    output logic                   count_en,
    output logic                   msg_valid,
    output logic [15:0]            msg_len,
    output logic                   pkt_done,
    output logic                   err,
    output logic [1:0]             err_code
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MSG_HDR  = 2'd1;
    localparam logic [1:0] MSG_BODY = 2'd2;
    localparam logic [1:0] DRAIN    = 2'd3;
    localparam logic [15:0] MAX_L   = 16'(MAX_LEN);

    logic [1:0]  state, state_n, code;
    logic [15:0] msg_rem, byte_rem, fld, rem_n, msg_rem_n;
    logic [3:0]  take;
    logic [7:0]  keep;
    logic        in_hdr, acc, fin, len_bad, mask_bad;
    logic        fwd, eop, ok, e, done, m_ok;

    assign fld       = s_tdata[15:0];
    assign in_hdr    = state == MSG_HDR;
    assign s_tready  = rst & (state == DRAIN | !m_valid | m_ready);
    assign acc       = s_tvalid & s_tready;
    // Header beat carries the 2-byte length, so at most 6 payload bytes start at lane 2.
    assign take      = in_hdr ? (fld > 16'd6 ? 4'd6 : fld[3:0]) : (byte_rem > 16'd8 ? 4'd8 : byte_rem[3:0]);
    assign keep      = in_hdr ? 8'hFC & (8'hFF >> (4'd6 - take)) : 8'hFF >> (4'd8 - take);
    assign rem_n     = (in_hdr ? fld : byte_rem) - {12'd0, take};
    assign fin       = rem_n == 16'd0;
    assign len_bad   = fld == 16'd0 || fld > MAX_L;
    assign mask_bad  = |(keep & ~s_tkeep);
    assign msg_rem_n = msg_rem - 16'd1;
    assign count_en  = m_valid & m_sop;
    assign msg_valid = m_valid & m_ready & m_eop & m_ok;

    always_comb begin
        state_n = state;
        fwd     = 1'b0;
        eop     = 1'b0;
        ok      = 1'b0;
        e       = 1'b0;
        code    = err_code;
        done    = 1'b0;
        if (acc) begin
            if (state == IDLE) begin
                if (fld == 16'd0) begin
                    e       = 1'b1;
                    code    = 2'd1;
                    state_n = s_tlast ? IDLE : DRAIN;
                end else if (s_tlast) begin
                    e    = 1'b1;
                    code = 2'd2;
                end else begin
                    state_n = MSG_HDR;
                end
            end else if (state == DRAIN) begin
                state_n = s_tlast ? IDLE : DRAIN;
            end else if ((in_hdr && len_bad) || mask_bad) begin
                e       = 1'b1;
                code    = (in_hdr && len_bad) ? 2'd1 : 2'd2;
                state_n = s_tlast ? IDLE : DRAIN;
            end else begin
                fwd = 1'b1;
                eop = fin | s_tlast;
                ok  = fin;
                if (!fin) begin
                    e       = s_tlast;
                    code    = s_tlast ? 2'd2 : err_code;
                    state_n = s_tlast ? IDLE : MSG_BODY;
                end else if (msg_rem_n == 16'd0) begin
                    done    = s_tlast;
                    e       = !s_tlast;
                    code    = s_tlast ? err_code : 2'd3;
                    state_n = s_tlast ? IDLE : DRAIN;
                end else begin
                    e       = s_tlast;
                    code    = s_tlast ? 2'd2 : err_code;
                    state_n = s_tlast ? IDLE : MSG_HDR;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            msg_rem  <= '0;
            byte_rem <= '0;
            msg_len  <= '0;
            err      <= 1'b0;
            err_code <= '0;
            pkt_done <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_keep   <= '0;
            m_sop    <= 1'b0;
            m_eop    <= 1'b0;
            m_ok     <= 1'b0;
        end else begin
            state    <= state_n;
            err      <= e;
            err_code <= code;
            pkt_done <= done;
            if (acc && state == IDLE)
                msg_rem <= fld;
            else if (fwd && ok)
                msg_rem <= msg_rem_n;
            if (fwd)
                byte_rem <= rem_n;
            if (fwd && in_hdr)
                msg_len <= fld;
            if (fwd) begin
                m_valid <= 1'b1;
                m_data  <= s_tdata;
                m_keep  <= keep;
                m_sop   <= in_hdr;
                m_eop   <= eop;
                m_ok    <= ok;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_msg_frame_ctrl.sv
// tb_msg_frame_ctrl: table-driven packets with an expected-beat scoreboard and per-packet
// pulse/err/msg_len expectations, plus backpressure and async-reset sequences.
module tb_msg_frame_ctrl;
    logic        clk = 0, rst = 0, s_tvalid = 0, s_tlast = 0, m_ready = 1;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tready, m_valid, m_sop, m_eop, count_en, msg_valid, pkt_done, err;
    logic [63:0] m_data;
    logic [7:0]  m_keep;
    logic [15:0] msg_len;
    logic [1:0]  err_code;

    msg_frame_ctrl dut (
        .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_keep(m_keep), .m_sop(m_sop), .m_eop(m_eop), .count_en(count_en),
        .msg_valid(msg_valid), .msg_len(msg_len), .pkt_done(pkt_done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {int pk; logic [15:0] f; logic [7:0] kp; logic lst; logic fw; logic [7:0] ek; logic sp; logic ep;} vec_t;
    typedef struct {int mv; int pd; int ne; logic [1:0] code; logic [15:0] ml;} pexp_t;
    typedef struct {logic [63:0] d; logic [7:0] k; logic s; logic e;} beat_t;

    vec_t  vt[$];
    pexp_t pe[$];
    beat_t q[$];
    int    tests = 0, fails = 0, n_mv = 0, n_pd = 0, n_err = 0;
    logic  tog = 0, took = 0;

    function automatic void add(int pk, logic [15:0] f, logic [7:0] kp, logic lst, logic fw,
                                logic [7:0] ek, logic sp, logic ep);
        vec_t v = '{pk, f, kp, lst, fw, ek, sp, ep};
        vt.push_back(v);
    endfunction

    function automatic void addp(int mv, int pd, int ne, logic [1:0] code, logic [15:0] ml);
        pexp_t p = '{mv, pd, ne, code, ml};
        pe.push_back(p);
    endfunction

    function automatic logic [63:0] mk(logic [15:0] f, int i);
        logic [7:0] t = i[7:0];
        return {{6{t}}, f};
    endfunction

    function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endfunction

    task automatic mon();
        beat_t b;
        if (msg_valid) n_mv++;
        if (pkt_done) n_pd++;
        if (err) n_err++;
        if (err && pkt_done) begin
            tests++;
            fails++;
            $display("FAIL err_and_pkt_done: both high at %0t", $time);
        end
        if (m_valid && m_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_beat: got data %0h with no expected beat", m_data);
            end else begin
                b = q.pop_front();
                chk("m_data", m_data, b.d);
                chk("m_keep", {56'd0, m_keep}, {56'd0, b.k});
                chk("m_sop", {63'd0, m_sop}, {63'd0, b.s});
                chk("m_eop", {63'd0, m_eop}, {63'd0, b.e});
                chk("count_en", {63'd0, count_en}, {63'd0, b.s});
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        took = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        if (tog) m_ready = ~m_ready;
    endtask

    task automatic send(vec_t v, int idx);
        int t = 0;
        beat_t b;
        s_tvalid = 1;
        s_tdata  = mk(v.f, idx);
        s_tkeep  = v.kp;
        s_tlast  = v.lst;
        do begin
            tick();
            t++;
        end while (!took && t < 100);
        if (!took) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: beat %0d not accepted, got 0 required 1", idx);
        end else if (v.fw) begin
            b = '{mk(v.f, idx), v.ek, v.sp, v.ep};
            q.push_back(b);
        end
    endtask

    task automatic drain();
        int t = 0;
        s_tvalid = 0;
        s_tlast  = 0;
        while (q.size() != 0 && t < 60) begin
            tick();
            t++;
        end
        tick();
        tick();
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic run_pkt(int p);
        int mv0 = n_mv, pd0 = n_pd, e0 = n_err;
        foreach (vt[i]) if (vt[i].pk == p) send(vt[i], i);
        drain();
        chk($sformatf("pkt%0d msg_valid count", p), 64'(n_mv - mv0), 64'(pe[p].mv));
        chk($sformatf("pkt%0d pkt_done count", p), 64'(n_pd - pd0), 64'(pe[p].pd));
        chk($sformatf("pkt%0d err count", p), 64'(n_err - e0), 64'(pe[p].ne));
        if (pe[p].ne > 0) chk($sformatf("pkt%0d err_code", p), {62'd0, err_code}, {62'd0, pe[p].code});
        chk($sformatf("pkt%0d msg_len", p), {48'd0, msg_len}, {48'd0, pe[p].ml});
    endtask

    task automatic chk_zero(string tag);
        chk({tag, " m_valid"}, {63'd0, m_valid}, 0);
        chk({tag, " m_data"}, m_data, 0);
        chk({tag, " m_keep"}, {56'd0, m_keep}, 0);
        chk({tag, " m_sop"}, {63'd0, m_sop}, 0);
        chk({tag, " m_eop"}, {63'd0, m_eop}, 0);
        chk({tag, " count_en"}, {63'd0, count_en}, 0);
        chk({tag, " msg_valid"}, {63'd0, msg_valid}, 0);
        chk({tag, " pkt_done"}, {63'd0, pkt_done}, 0);
        chk({tag, " err"}, {63'd0, err}, 0);
        chk({tag, " err_code"}, {62'd0, err_code}, 0);
        chk({tag, " msg_len"}, {48'd0, msg_len}, 0);
        chk({tag, " s_tready"}, {63'd0, s_tready}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // pk, field, tkeep, tlast, forwarded, exp keep, sop, eop
        add(0, 16'd1, 8'hFF, 0, 0, 8'h00, 0, 0);  add(0, 16'd6, 8'hFF, 1, 1, 8'hFC, 1, 1);
        add(1, 16'd2, 8'hFF, 0, 0, 8'h00, 0, 0);  add(1, 16'd10, 8'hFF, 0, 1, 8'hFC, 1, 0);
        add(1, 16'h5A5A, 8'hFF, 0, 1, 8'h0F, 0, 1); add(1, 16'd3, 8'hFF, 1, 1, 8'h1C, 1, 1);
        add(2, 16'd3, 8'hFF, 0, 0, 8'h00, 0, 0);  add(2, 16'd6, 8'hFF, 0, 1, 8'hFC, 1, 1);
        add(2, 16'd2, 8'hFF, 1, 1, 8'h0C, 1, 1);
        add(3, 16'd1, 8'hFF, 0, 0, 8'h00, 0, 0);  add(3, 16'd1, 8'hFF, 1, 1, 8'h04, 1, 1);
        add(4, 16'd1, 8'hFF, 0, 0, 8'h00, 0, 0);  add(4, 16'd0, 8'hFF, 0, 0, 8'h00, 0, 0);
        add(4, 16'h1111, 8'hFF, 0, 0, 8'h00, 0, 0); add(4, 16'h2222, 8'hFF, 1, 0, 8'h00, 0, 0);
        add(5, 16'd1, 8'hFF, 0, 0, 8'h00, 0, 0);  add(5, 16'd6, 8'hFF, 0, 1, 8'hFC, 1, 1);
        add(5, 16'h3333, 8'hFF, 0, 0, 8'h00, 0, 0); add(5, 16'h4444, 8'hFF, 1, 0, 8'h00, 0, 0);
        add(6, 16'd0, 8'hFF, 1, 0, 8'h00, 0, 0);
        add(7, 16'd1, 8'hFF, 0, 0, 8'h00, 0, 0);  add(7, 16'd1501, 8'hFF, 1, 0, 8'h00, 0, 0);
        add(8, 16'd1, 8'hFF, 0, 0, 8'h00, 0, 0);  add(8, 16'd20, 8'hFF, 0, 1, 8'hFC, 1, 0);
        add(8, 16'h5555, 8'hFF, 1, 1, 8'hFF, 0, 1);
        add(9, 16'd1, 8'hFF, 0, 0, 8'h00, 0, 0);  add(9, 16'd6, 8'h7F, 1, 0, 8'h00, 0, 0);
        add(10, 16'd1, 8'hFF, 0, 0, 8'h00, 0, 0); add(10, 16'd14, 8'hFF, 0, 1, 8'hFC, 1, 0);
        add(10, 16'h6666, 8'hFF, 1, 1, 8'hFF, 0, 1);
        add(11, 16'd1, 8'hFF, 0, 0, 8'h00, 0, 0); add(11, 16'd1500, 8'hFF, 1, 1, 8'hFC, 1, 1);
        // msg_valid, pkt_done, err pulses, last err_code, msg_len after packet
        addp(1, 1, 0, 2'd0, 16'd6);   addp(2, 1, 0, 2'd0, 16'd3);
        addp(2, 0, 1, 2'd2, 16'd2);   addp(1, 1, 0, 2'd0, 16'd1);
        addp(0, 0, 1, 2'd1, 16'd1);   addp(1, 0, 1, 2'd3, 16'd6);
        addp(0, 0, 1, 2'd1, 16'd6);   addp(0, 0, 1, 2'd1, 16'd6);
        addp(0, 0, 1, 2'd2, 16'd20);  addp(0, 0, 1, 2'd2, 16'd20);
        addp(1, 1, 0, 2'd0, 16'd14);  addp(0, 0, 1, 2'd2, 16'd1500);

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1;
        for (int pass = 0; pass < 2; pass++) begin
            tog     = pass[0];
            m_ready = 1;
            for (int p = 0; p < pe.size(); p++) run_pkt(p);
        end
        tog     = 0;
        m_ready = 1;

        m_ready = 0;
        v = '{99, 16'd1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        send(v, 200);
        v = '{99, 16'd6, 8'hFF, 1'b1, 1'b1, 8'hFC, 1'b1, 1'b1};
        send(v, 201);
        s_tvalid = 0;
        tick();
        tick();
        chk("hold m_valid", {63'd0, m_valid}, 1);
        chk("hold s_tready", {63'd0, s_tready}, 0);
        chk("hold m_keep", {56'd0, m_keep}, 64'hFC);
        chk("hold count_en", {63'd0, count_en}, 1);
        chk("hold msg_valid", {63'd0, msg_valid}, 0);
        m_ready = 1;
        drain();

        m_ready = 0;
        v = '{99, 16'd1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        send(v, 210);
        v = '{99, 16'd20, 8'hFF, 1'b0, 1'b1, 8'hFC, 1'b1, 1'b0};
        send(v, 211);
        s_tvalid = 0;
        tick();
        #2 rst = 0;
        #1 chk_zero("async_rst");
        q.delete();
        m_ready = 1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1;
        run_pkt(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
